icmp_server_deadlock_report_arbiter: RTL and testbench
======================================================

// Module: icmp_server_deadlock_report_arbiter
// PURPOSE
//  Collects block/info outputs from NUM_MON per-instance deadlock monitors in the ICMP server.
//  Filters transient stalls with a per-monitor persistence counter.
//  Round-robin arbitrates confirmed deadlocks onto one valid/ready report channel for the debug/host path.
//  Keeps a sticky global deadlock flag until software clears it.
// PARAMETERS
//  NUM_MON   4   number of monitor inputs (>=1)
//  INFO_W    4   width of each monitor's axis_block_info
//  THRESH_W  16  width of persistence threshold/counters
//  TS_W      32  width of free-running timestamp
//  ID_W      2   clog2(NUM_MON), min 1
// PORTS
//  clock          in   1                 system clock, all logic posedge
//  reset          in   1                 synchronous, active-high
//  mon_block      in   NUM_MON           block output of each monitor
//  mon_info       in   NUM_MON*INFO_W    axis_block_info of each monitor, monitor i at [i*INFO_W +: INFO_W]
//  cfg_enable     in   1                 0: counters held at 0, no new pending
//  cfg_threshold  in   THRESH_W          consecutive blocked cycles to confirm; 0 treated as 1
//  clear          in   1                 one-cycle pulse: drop pending/reported state, drop deadlock_flag
//  rpt_valid      out  1                 report record valid
//  rpt_ready      in   1                 consumer accepts record
//  rpt_id         out  ID_W              index of reporting monitor
//  rpt_info       out  INFO_W            mon_info snapshot taken at confirmation
//  rpt_timestamp  out  TS_W              timestamp snapshot taken at confirmation
//  pending        out  NUM_MON           confirmed, not yet reported
//  deadlock_flag  out  1                 sticky: set on any accepted report
// BEHAVIOUR
//  Reset: all outputs 0; counters, timestamp and snapshots 0; FSM in IDLE; rr pointer 0.
//  Timestamp: free-running +1 per cycle; wraps 2^TS_W-1 -> 0.
//  Persistence counter, per monitor:
//   - Increments when cfg_enable && mon_block[i]; saturates at 2^THRESH_W-1.
//   - Cleared to 0 on any cycle with mon_block[i]=0, cfg_enable=0, or clear.
//  Confirmation:
//   - On the edge where the counter reaches max(cfg_threshold,1) and reported[i]=0: set pending[i].
//   - Capture the mon_info slice and the timestamp on that same edge.
//   - Consequence: mon_block sampled high on T consecutive edges -> pending[i] at edge T.
//  Reported bit:
//   - reported[i] is set on report handshake.
//   - It is cleared when mon_block[i] is sampled low or on clear.
//   - One report per continuous blocked episode.
//  pending[i]:
//   - Cleared by its own handshake or by clear.
//   - Not cleared by mon_block dropping; a confirmed deadlock is always reported.
//  FSM, IDLE / SEND:
//   - IDLE: if pending != 0, grant the first pending index at or after rr_ptr (wrapping) and go to SEND.
//   - SEND entry: drive rpt_* from the granted snapshot.
//   - SEND: rpt_valid=1, rpt_id/info/timestamp held stable until rpt_valid&&rpt_ready.
//   - On handshake: clear pending[id], set reported[id], set deadlock_flag, rr_ptr=id+1 (mod NUM_MON), go to IDLE.
//   - Minimum one IDLE cycle between records, so sustained throughput is 1 record per 2 cycles.
//  Latency: pending at edge T -> rpt_valid at edge T+1 when the FSM is idle.
//  Simultaneous events:
//   - clear in IDLE: nothing granted that cycle.
//   - clear in SEND: the current record is not withdrawn. rpt_valid holds until handshake, then IDLE.
//   - clear in SEND still clears other pending bits, all reported bits and deadlock_flag.
//   - Handshake and clear on the same edge: deadlock_flag ends 0 (clear wins).
//   - Confirmation of the granted index during SEND cannot occur, because reported/pending already block it.
//   - Confirmation and handshake of different indices on the same edge: both take effect.
//   - cfg_threshold change mid-count: compared live; a counter already above the new value does not confirm until it restarts.
//  Reset mid-SEND: rpt_valid drops immediately at the reset edge; the only permitted valid drop without ready.
// STRUCTURE
//  Package icmp_deadlock_pkg:
//   - state enum {IDLE, SEND}
//   - report record struct {id, info, timestamp}
//   - default NUM_MON/INFO_W/THRESH_W/TS_W constants
//  Sub-module icmp_deadlock_persist_ctr, one per monitor via generate:
//   - Counter, confirm pulse, reported bit.
//   - Ports: clock, reset, block, enable, clear, threshold, ack -> confirm.
//  Top holds timestamp, snapshots, pending, rr arbiter, FSM and output registers.
// TESTING
//  1. T=3, mon_block[1] high 3 cycles, info=4'b1110, rpt_ready=1 -> pending[1] at edge 3, rpt_valid edge 4, id=1, info=4'b1110, flag=1.
//  2. T=3, mon_block[2] high 2 cycles, low 1, high 2 -> no pending, rpt_valid never asserts, counters back to 0.
//  3. Monitors 0 and 3 confirm same edge, rr_ptr=0, rpt_ready=1 -> records id=0 then id=3 on edges 2 apart; then rr_ptr=0.
//  4. rpt_ready=0 for 10 cycles while SEND -> rpt_* constant 10 cycles; ready=1 -> single handshake, pending bit drops.
//  5. Block held 100 cycles, T=5 -> exactly one report; drop block 1 cycle and re-raise -> second report 5 edges later.
//  6. clear during SEND with ready=0, another index pending -> current record held then accepted, other pending=0, flag=0; T=0 -> confirm after 1 blocked edge.

Source files
------------

// File: rtl/icmp_server_deadlock_report_arbiter_pkg.sv
// Shared types and default sizing for the ICMP server deadlock report arbiter.
// Holds the FSM state encoding, the report record layout and a ring-index helper.
package icmp_deadlock_pkg;

   localparam int NUM_MON_DEF  = 4;
   localparam int INFO_W_DEF   = 4;
   localparam int THRESH_W_DEF = 16;
   localparam int TS_W_DEF     = 32;
   localparam int ID_W_DEF     = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [ID_W_DEF-1:0]   id;
      logic [INFO_W_DEF-1:0] info;
      logic [TS_W_DEF-1:0]   timestamp;
   } rpt_rec_t;

   // Successor of idx on a ring of n entries.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/icmp_server_deadlock_report_arbiter_if.sv
// Valid/ready report channel carrying one confirmed deadlock record.
// The arbiter drives the master side; the debug/host consumer is the slave.
interface icmp_server_deadlock_report_arbiter_if #(
   parameter int ID_W   = 2,
   parameter int INFO_W = 4,
   parameter int TS_W   = 32
) ();
   logic              rpt_valid;
   logic              rpt_ready;
   logic [ID_W-1:0]   rpt_id;
   logic [INFO_W-1:0] rpt_info;
   logic [TS_W-1:0]   rpt_timestamp;

   modport master (
      output rpt_valid,
      output rpt_id,
      output rpt_info,
      output rpt_timestamp,
      input  rpt_ready
   );

   modport slave (
      input  rpt_valid,
      input  rpt_id,
      input  rpt_info,
      input  rpt_timestamp,
      output rpt_ready
   );
endinterface

// File: rtl/icmp_server_deadlock_report_arbiter_persist.sv
// Per-monitor persistence filter: counts consecutive blocked cycles and pulses
// confirm once per blocked episode when the count first reaches the threshold.
module icmp_deadlock_persist_ctr
   import icmp_deadlock_pkg::*;
#(
   parameter int THRESH_W = THRESH_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                block,
   input  logic                enable,
   input  logic                clear,
   input  logic [THRESH_W-1:0] threshold,
   input  logic                ack,
   output logic                confirm
);

   logic [THRESH_W-1:0] r_cnt;
   logic                r_reported;
   logic [THRESH_W-1:0] w_cnt_inc;
   logic [THRESH_W-1:0] w_thr_eff;
   logic                w_run;

   assign w_run     = enable && block && !clear;
   assign w_thr_eff = (threshold == '0) ? THRESH_W'(1) : threshold;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + THRESH_W'(1);

   // Fires only on the step onto the threshold, so a saturated counter or one
   // already past a lowered threshold stays quiet until it restarts.
   assign confirm = w_run && !r_reported
                    && (w_cnt_inc == w_thr_eff) && (r_cnt != w_thr_eff);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt      <= '0;
         r_reported <= 1'b0;
      end else begin
         r_cnt <= w_run ? w_cnt_inc : '0;
         if (clear || !block) begin
            r_reported <= 1'b0;
         end else if (ack) begin
            r_reported <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/icmp_server_deadlock_report_arbiter.sv
// Filters per-monitor deadlock indications, snapshots them on confirmation and
// round-robin serialises them onto one report channel with a sticky global flag.
module icmp_server_deadlock_report_arbiter
   import icmp_deadlock_pkg::*;
#(
   parameter int NUM_MON  = NUM_MON_DEF,
   parameter int INFO_W   = INFO_W_DEF,
   parameter int THRESH_W = THRESH_W_DEF,
   parameter int TS_W     = TS_W_DEF,
   parameter int ID_W     = ID_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_MON-1:0]        mon_block,
   input  logic [NUM_MON*INFO_W-1:0] mon_info,
   input  logic                      cfg_enable,
   input  logic [THRESH_W-1:0]       cfg_threshold,
   input  logic                      clear,
   icmp_server_deadlock_report_arbiter_if.master rpt,
   output logic [NUM_MON-1:0]        pending,
   output logic                      deadlock_flag
);

   state_t              r_state;
   logic [TS_W-1:0]     r_ts;
   logic [NUM_MON-1:0]  r_pending;
   logic [INFO_W-1:0]   r_snap_info [NUM_MON];
   logic [TS_W-1:0]     r_snap_ts   [NUM_MON];
   logic [ID_W-1:0]     r_rr;
   logic [ID_W-1:0]     r_id;
   logic [INFO_W-1:0]   r_info;
   logic [TS_W-1:0]     r_tstamp;
   logic                r_valid;
   logic                r_flag;

   logic [NUM_MON-1:0]  w_confirm;
   logic [NUM_MON-1:0]  w_ack;
   logic [NUM_MON-1:0]  w_set;
   logic [NUM_MON-1:0]  w_pend_nxt;
   logic                w_hs;
   logic                w_grant_vld;
   logic [ID_W-1:0]     w_grant_id;
   logic [ID_W-1:0]     w_scan_idx;

   assign w_hs = r_valid && rpt.rpt_ready;

   for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
      assign w_ack[g] = w_hs && (r_id == ID_W'(g));
      // A monitor that is already pending keeps its first snapshot.
      assign w_set[g] = w_confirm[g] && !r_pending[g];

      icmp_deadlock_persist_ctr #(
         .THRESH_W (THRESH_W)
      ) u_persist (
         .clock     (clock),
         .reset     (reset),
         .block     (mon_block[g]),
         .enable    (cfg_enable),
         .clear     (clear),
         .threshold (cfg_threshold),
         .ack       (w_ack[g]),
         .confirm   (w_confirm[g])
      );

      always_ff @(posedge clock) begin
         if (reset) begin
            r_snap_info[g] <= '0;
            r_snap_ts[g]   <= '0;
         end else if (w_set[g]) begin
            r_snap_info[g] <= mon_info[g*INFO_W +: INFO_W];
            r_snap_ts[g]   <= r_ts;
         end
      end
   end

   assign w_pend_nxt = clear ? '0 : ((r_pending & ~w_ack) | w_set);

   // Scan downward so the last hit is the first pending index at or after r_rr.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_id  = '0;
      w_scan_idx  = '0;
      for (int k = NUM_MON - 1; k >= 0; k--) begin
         w_scan_idx = ID_W'((int'(r_rr) + k) % NUM_MON);
         if (r_pending[w_scan_idx]) begin
            w_grant_vld = 1'b1;
            w_grant_id  = w_scan_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ts      <= '0;
         r_pending <= '0;
         r_rr      <= '0;
         r_id      <= '0;
         r_info    <= '0;
         r_tstamp  <= '0;
         r_valid   <= 1'b0;
         r_flag    <= 1'b0;
      end else begin
         r_ts      <= r_ts + TS_W'(1);
         r_pending <= w_pend_nxt;
         if (clear) begin
            r_flag <= 1'b0;
         end else if (w_hs) begin
            r_flag <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (!clear && w_grant_vld) begin
                  r_state  <= SEND;
                  r_valid  <= 1'b1;
                  r_id     <= w_grant_id;
                  r_info   <= r_snap_info[w_grant_id];
                  r_tstamp <= r_snap_ts[w_grant_id];
               end
            end
            SEND: begin
               // clear never withdraws an offered record; only the handshake ends it.
               if (w_hs) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
                  r_rr    <= ID_W'(next_idx(int'(r_id), NUM_MON));
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign rpt.rpt_valid     = r_valid;
   assign rpt.rpt_id        = r_id;
   assign rpt.rpt_info      = r_info;
   assign rpt.rpt_timestamp = r_tstamp;
   assign pending           = r_pending;
   assign deadlock_flag     = r_flag;

endmodule

// File: tb/tb_icmp_server_deadlock_report_arbiter.sv
// Directed bench for the deadlock report arbiter: a per-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_icmp_server_deadlock_report_arbiter;
   import icmp_deadlock_pkg::*;

   localparam int NUM_MON  = 4;
   localparam int INFO_W   = 4;
   localparam int THRESH_W = 16;
   localparam int TS_W     = 32;
   localparam int ID_W     = 2;
   localparam int NVEC     = 28;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_MON-1:0]        mon_block;
   logic [NUM_MON*INFO_W-1:0] mon_info;
   logic                      cfg_enable;
   logic [THRESH_W-1:0]       cfg_threshold;
   logic                      clear;
   logic                      rpt_ready;
   logic [NUM_MON-1:0]        pending;
   logic                      deadlock_flag;

   icmp_server_deadlock_report_arbiter_if #(
      .ID_W(ID_W), .INFO_W(INFO_W), .TS_W(TS_W)
   ) rpt_if ();

   assign rpt_if.rpt_ready = rpt_ready;

   icmp_server_deadlock_report_arbiter #(
      .NUM_MON(NUM_MON), .INFO_W(INFO_W), .THRESH_W(THRESH_W),
      .TS_W(TS_W), .ID_W(ID_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mon_block     (mon_block),
      .mon_info      (mon_info),
      .cfg_enable    (cfg_enable),
      .cfg_threshold (cfg_threshold),
      .clear         (clear),
      .rpt           (rpt_if.master),
      .pending       (pending),
      .deadlock_flag (deadlock_flag)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0]  blk;
      logic        en;
      logic        clr;
      logic        rdy;
      logic        exp_valid;
      logic [1:0]  exp_id;
      logic [3:0]  exp_info;
      logic [31:0] exp_ts;
      logic [3:0]  exp_pend;
      logic        exp_flag;
   } vec_t;

   vec_t vecs [NVEC];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      mon_block     = '0;
      mon_info      = '0;
      cfg_enable    = 1'b0;
      cfg_threshold = '0;
      clear         = 1'b0;
      rpt_ready     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int       nvalid;
      int       first_e;
      rpt_rec_t rec;

      // Table: thr=3, mon_info slices {0,A,E,0}; row k is checked after edge k+1.
      vecs[0]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[1]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[2]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0010, 1'b0};
      vecs[3]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'hE, 32'd2,  4'b0010, 1'b0};
      vecs[4]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[6]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[7]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[8]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[9]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[10] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[12] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[13] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[14] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0100, 1'b1};
      vecs[15] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'hA, 32'd14, 4'b0100, 1'b1};
      vecs[16] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[17] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[18] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[19] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[20] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[21] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b1};
      vecs[22] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[23] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[24] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[25] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0100, 1'b0};
      vecs[26] = '{4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};
      vecs[27] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0,  4'b0000, 1'b0};

      do_reset();
      chk("reset_state",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp, pending, deadlock_flag},
          64'd0);

      cfg_threshold = 16'd3;
      mon_info      = 16'h0AE0;
      for (int i = 0; i < NVEC; i++) begin
         mon_block  = vecs[i].blk;
         cfg_enable = vecs[i].en;
         clear      = vecs[i].clr;
         rpt_ready  = vecs[i].rdy;
         tick();
         if (vecs[i].exp_valid)
            chk($sformatf("vec%0d", i),
                {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp, pending, deadlock_flag},
                {vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_info, vecs[i].exp_ts, vecs[i].exp_pend, vecs[i].exp_flag});
         else
            chk($sformatf("vec%0d", i),
                {rpt_if.rpt_valid, pending, deadlock_flag},
                {vecs[i].exp_valid, vecs[i].exp_pend, vecs[i].exp_flag});
      end
      clear = 1'b0;

      // Round robin on a simultaneous confirm, then a long ready=0 stall.
      do_reset();
      cfg_enable = 1'b1; cfg_threshold = 16'd2; mon_info = 16'h5003;
      rpt_ready = 1'b1; mon_block = 4'b1001;
      tick(); tick();
      chk("rr_confirm", {28'd0, pending}, {28'd0, 4'b1001});
      tick();
      chk("rr_first", {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info}, {1'b1, 2'd0, 4'h3});
      tick();
      chk("rr_gap", {rpt_if.rpt_valid, pending}, {1'b0, 4'b1000});
      tick();
      chk("rr_second", {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info}, {1'b1, 2'd3, 4'h5});
      tick();
      chk("rr_done", {rpt_if.rpt_valid, pending, deadlock_flag}, {1'b0, 4'b0000, 1'b1});
      mon_block = 4'b0000;
      tick();
      mon_block = 4'b1001; rpt_ready = 1'b0;
      tick(); tick();
      chk("rr_reconfirm", {28'd0, pending}, {28'd0, 4'b1001});
      tick();
      chk("rr_wrap_first",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp},
          {1'b1, 2'd0, 4'h3, 32'd8});
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("stall_hold%0d", c),
             {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp, pending},
             {1'b1, 2'd0, 4'h3, 32'd8, 4'b1001});
      end
      rpt_ready = 1'b1;
      tick();
      chk("stall_accept", {rpt_if.rpt_valid, pending}, {1'b0, 4'b1000});
      tick();
      chk("stall_next",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp},
          {1'b1, 2'd3, 4'h5, 32'd8});
      tick();
      chk("stall_done", {rpt_if.rpt_valid, pending}, {1'b0, 4'b0000});

      // One report per blocked episode over a long block, then a fresh episode.
      do_reset();
      cfg_enable = 1'b1; cfg_threshold = 16'd5; mon_info = 16'h0700;
      rpt_ready = 1'b1; mon_block = 4'b0100;
      nvalid = 0; first_e = 0; rec = '0;
      for (int e = 1; e <= 100; e++) begin
         tick();
         if (rpt_if.rpt_valid) begin
            nvalid++;
            if (first_e == 0) begin
               first_e = e;
               rec = '{rpt_if.rpt_id, rpt_if.rpt_info, rpt_if.rpt_timestamp};
            end
         end
      end
      chk("ep1_count", 64'(nvalid), 64'd1);
      chk("ep1_edge", 64'(first_e), 64'd6);
      chk("ep1_record", 64'(rec), 64'(rpt_rec_t'{2'd2, 4'h7, 32'd4}));
      mon_block = 4'b0000;
      tick();
      mon_block = 4'b0100;
      nvalid = 0; first_e = 0;
      for (int e = 102; e <= 125; e++) begin
         tick();
         if (rpt_if.rpt_valid) begin
            nvalid++;
            if (first_e == 0) first_e = e;
         end
      end
      chk("ep2_count", 64'(nvalid), 64'd1);
      chk("ep2_edge", 64'(first_e), 64'd107);

      // clear while a record is offered, T=0, and handshake colliding with clear.
      do_reset();
      cfg_enable = 1'b1; cfg_threshold = 16'd2; mon_info = 16'h0021;
      rpt_ready = 1'b0; mon_block = 4'b0011;
      tick(); tick();
      chk("clr_pend", {28'd0, pending}, {28'd0, 4'b0011});
      tick();
      chk("clr_offer", {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info}, {1'b1, 2'd0, 4'h1});
      mon_block = 4'b0000; clear = 1'b1;
      tick();
      chk("clr_edge",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, pending, deadlock_flag},
          {1'b1, 2'd0, 4'h1, 4'b0000, 1'b0});
      clear = 1'b0;
      tick();
      chk("clr_hold",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, pending, deadlock_flag},
          {1'b1, 2'd0, 4'h1, 4'b0000, 1'b0});
      rpt_ready = 1'b1;
      tick();
      chk("clr_accept", {rpt_if.rpt_valid, pending}, {1'b0, 4'b0000});
      cfg_threshold = 16'd0; mon_block = 4'b0001;
      tick();
      chk("thr0_confirm", {28'd0, pending}, {28'd0, 4'b0001});
      mon_block = 4'b0000;
      tick();
      chk("thr0_offer",
          {rpt_if.rpt_valid, rpt_if.rpt_id, rpt_if.rpt_info, deadlock_flag},
          {1'b1, 2'd0, 4'h1, 1'b1});
      clear = 1'b1;
      tick();
      chk("hs_clr_flag", {rpt_if.rpt_valid, pending, deadlock_flag}, {1'b0, 4'b0000, 1'b0});
      clear = 1'b0;

      // Reset while a record is offered drops valid at the reset edge.
      rpt_ready = 1'b0; mon_block = 4'b0001;
      tick();
      mon_block = 4'b0000;
      tick();
      chk("pre_reset_offer", {63'd0, rpt_if.rpt_valid}, 64'd1);
      reset = 1'b1;
      tick();
      chk("reset_mid_send", {rpt_if.rpt_valid, pending, deadlock_flag}, {1'b0, 4'b0000, 1'b0});
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
